// File: rtl/axi_ram_pkg.sv
// Shared definitions for the AXI3-subset SRAM responder: burst and response
// codes plus the transaction FSM state encoding.
package axi_ram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_LOAD,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_e;

endpackage

// File: rtl/axi_ram_if.sv
// AXI3-subset channel bundle (AR, R, AW, W, B) between a single-outstanding
// master and the SRAM responder.
interface axi_ram_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/axi_ram_addr_gen.sv
// Next-beat byte address for FIXED and INCR bursts; unknown burst codes
// advance like INCR and the 32-bit sum wraps naturally.
module axi_ram_addr_gen
  import axi_ram_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  always_comb begin
    next_addr = addr;
    if (burst != BURST_FIXED) begin
      next_addr = addr + (32'd1 << size);
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3-subset slave serving one transaction at a time from a synchronous
// single-port SRAM with one cycle of read latency.
module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  axi_ram_if.slave              bus,
  output logic                  sram_en,
  output logic [3:0]            sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  state_e      state, state_nxt;
  logic [3:0]  id_r;
  logic [31:0] addr_r;
  logic [3:0]  len_r;
  logic [2:0]  size_r;
  logic [1:0]  burst_r;
  logic [3:0]  beat_r;
  logic [31:0] rdata_r;
  logic [31:0] next_addr;
  logic        last_beat;

  // The upper length nibbles and wlast carry no information for this slave.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.wlast, bus.arlen[7:4], bus.awlen[7:4]};

  assign last_beat = (beat_r == len_r);

  axi_ram_addr_gen u_addr_gen (
    .addr      (addr_r),
    .size      (size_r),
    .burst     (burst_r),
    .next_addr (next_addr)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_r    <= '0;
      addr_r  <= '0;
      len_r   <= '0;
      size_r  <= '0;
      burst_r <= '0;
      beat_r  <= '0;
      rdata_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.awvalid) begin
            id_r    <= bus.awid;
            addr_r  <= bus.awaddr;
            len_r   <= bus.awlen[3:0];
            size_r  <= bus.awsize;
            burst_r <= bus.awburst;
            beat_r  <= '0;
          end else if (bus.arvalid) begin
            id_r    <= bus.arid;
            addr_r  <= bus.araddr;
            len_r   <= bus.arlen[3:0];
            size_r  <= bus.arsize;
            burst_r <= bus.arburst;
            beat_r  <= '0;
          end
        end
        RD_LOAD: rdata_r <= sram_rdata;
        RD_DATA: begin
          if (bus.rready && !last_beat) begin
            beat_r <= beat_r + 4'd1;
            addr_r <= next_addr;
          end
        end
        WR_DATA: begin
          if (bus.wvalid && !last_beat) begin
            beat_r <= beat_r + 4'd1;
            addr_r <= next_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    bus.arready = 1'b0;
    bus.awready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rid     = '0;
    bus.rresp   = RESP_OKAY;
    bus.rlast   = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bid     = '0;
    bus.bresp   = RESP_OKAY;
    sram_en     = 1'b0;
    sram_wen    = '0;
    sram_addr   = '0;
    sram_wdata  = '0;

    case (state)
      IDLE: begin
        bus.awready = 1'b1;
        bus.arready = !bus.awvalid;
        if (bus.awvalid)      state_nxt = WR_DATA;
        else if (bus.arvalid) state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        sram_en   = 1'b1;
        sram_addr = addr_r[ADDR_WIDTH+1:2];
        state_nxt = RD_LOAD;
      end
      RD_LOAD: state_nxt = RD_DATA;
      RD_DATA: begin
        bus.rvalid = 1'b1;
        bus.rdata  = rdata_r;
        bus.rid    = id_r;
        bus.rlast  = last_beat;
        if (bus.rready) state_nxt = last_beat ? IDLE : RD_ADDR;
      end
      WR_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          sram_wen   = bus.wstrb;
          sram_wdata = bus.wdata;
          sram_addr  = addr_r[ADDR_WIDTH+1:2];
          if (last_beat) state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        bus.bvalid = 1'b1;
        bus.bid    = id_r;
        if (bus.bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave with a behavioural
// synchronous SRAM; expected values are hand-computed constants.
module tb_axi_ram_slave;
  import axi_ram_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sram_en;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic [31:0]   mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  axi_ram_if bus ();

  axi_ram_slave #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) sram_rdata <= mem[sram_addr];
    for (int b = 0; b < 4; b++) begin
      if (sram_wen[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (sram_en && sram_wen != 4'd0) begin
        errors++;
        $display("FAIL sram_exclusive: sram_en=%b sram_wen=%b, required not both", sram_en, sram_wen);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = BURST_INCR;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = BURST_INCR;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, output bit ok);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd2;
    bus.arburst = burst; bus.arvalid = 1'b1;
    #1;
    ok = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (bus.arready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, output bit ok);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2;
    bus.awburst = burst; bus.awvalid = 1'b1;
    #1;
    ok = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (bus.awready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last, output bit ok);
    bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (bus.wready) begin ok = 1'b1; break; end
      tick();
    end
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic wait_rvalid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (bus.rvalid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic finish_b(output bit ok, output logic [3:0] id);
    ok = 1'b0;
    id = '0;
    for (int n = 0; n < 16; n++) begin
      if (bus.bvalid) begin ok = 1'b1; break; end
      tick();
    end
    id = bus.bid;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] addr, input logic [3:0] id, output logic [31:0] data,
                           output bit ok);
    bit ok_a, ok_r;
    send_ar(addr, 8'h00, BURST_INCR, id, ok_a);
    wait_rvalid(ok_r);
    ok = ok_a && ok_r;
    data = bus.rdata;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.arready !== 1'b1 || bus.awready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: arready=%b awready=%b, required 1 1", bus.arready, bus.awready);
    end
    checks++;
    if ({bus.rvalid, bus.wready, bus.bvalid, bus.rlast, sram_en} !== 5'b0 || sram_wen !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle: rvalid=%b wready=%b bvalid=%b rlast=%b sram_en=%b sram_wen=%b, required all 0",
               bus.rvalid, bus.wready, bus.bvalid, bus.rlast, sram_en, sram_wen);
    end
    checks++;
    if (bus.rdata !== 32'd0 || bus.rid !== 4'd0 || bus.bid !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h rid=%h bid=%h, required 0 0 0", bus.rdata, bus.rid, bus.bid);
    end
  endtask

  task automatic test_single_read();
    mem[5] = 32'hDEADBEEF;
    bus.arid = 4'd3; bus.araddr = 32'h14; bus.arlen = 8'h00; bus.arsize = 3'd2;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    #1;
    tick();
    bus.arvalid = 1'b0;
    checks++;
    if (sram_en !== 1'b1 || sram_addr !== 14'd5) begin
      errors++;
      $display("FAIL single_read_sram: sram_en=%b sram_addr=%0d at T+1, required 1 5", sram_en, sram_addr);
    end
    tick();
    checks++;
    if (bus.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_read_early: rvalid=%b at T+2, required 0", bus.rvalid);
    end
    tick();
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEADBEEF || bus.rid !== 4'd3 ||
        bus.rlast !== 1'b1 || bus.rresp !== RESP_OKAY) begin
      errors++;
      $display("FAIL single_read_beat: rvalid=%b rdata=%h rid=%0d rlast=%b rresp=%0d, required 1 deadbeef 3 1 0",
               bus.rvalid, bus.rdata, bus.rid, bus.rlast, bus.rresp);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      errors++;
      $display("FAIL single_read_done: rvalid=%b arready=%b, required 0 1", bus.rvalid, bus.arready);
    end
  endtask

  task automatic test_byte_write();
    bit ok;
    logic [31:0] data;
    mem[8] = 32'h11223344;
    send_aw(32'h22, 8'h00, BURST_INCR, 4'd6, ok);
    checks++;
    if (!ok || bus.wready !== 1'b1) begin
      errors++;
      $display("FAIL byte_write_wready: aw_ok=%b wready=%b at T+1, required 1 1", ok, bus.wready);
    end
    bus.wdata = 32'h00AB0000; bus.wstrb = 4'b0100; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    #1;
    checks++;
    if (sram_wen !== 4'b0100 || sram_addr !== 14'd8 || sram_wdata !== 32'h00AB0000 || sram_en !== 1'b0) begin
      errors++;
      $display("FAIL byte_write_sram: wen=%b addr=%0d wdata=%h en=%b, required 0100 8 00ab0000 0",
               sram_wen, sram_addr, sram_wdata, sram_en);
    end
    tick();
    bus.wvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bid !== 4'd6 || bus.bresp !== RESP_OKAY) begin
      errors++;
      $display("FAIL byte_write_b: bvalid=%b bid=%0d bresp=%0d, required 1 6 0", bus.bvalid, bus.bid, bus.bresp);
    end
    tick();
    checks++;
    if (bus.bvalid !== 1'b1 || bus.bid !== 4'd6) begin
      errors++;
      $display("FAIL byte_write_b_hold: bvalid=%b bid=%0d, required 1 6", bus.bvalid, bus.bid);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL byte_write_b_done: bvalid=%b, required 0", bus.bvalid);
    end
    read_word(32'h20, 4'd7, data, ok);
    checks++;
    if (!ok || data !== 32'h11AB3344) begin
      errors++;
      $display("FAIL byte_write_readback: ok=%b rdata=%h, required 1 11ab3344", ok, data);
    end
  endtask

  task automatic test_incr_burst();
    bit ok;
    for (int i = 0; i < 4; i++) mem[16+i] = 32'h10 + 32'(i);
    send_ar(32'h40, 8'hF3, BURST_INCR, 4'd9, ok);
    for (int i = 0; i < 4; i++) begin
      bit okr;
      wait_rvalid(okr);
      checks++;
      if (!ok || !okr || bus.rdata !== 32'h10 + 32'(i) || bus.rid !== 4'd9 || bus.rlast !== (i == 3)) begin
        errors++;
        $display("FAIL incr_beat%0d: ok=%b rdata=%h rid=%0d rlast=%b, required 1 %h 9 %b",
                 i, ok && okr, bus.rdata, bus.rid, bus.rlast, 32'h10 + 32'(i), i == 3);
      end
      if (i == 2) begin
        for (int s = 0; s < 2; s++) begin
          tick();
          checks++;
          if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h12 || bus.rlast !== 1'b0) begin
            errors++;
            $display("FAIL incr_stall%0d: rvalid=%b rdata=%h rlast=%b, required 1 00000012 0",
                     s, bus.rvalid, bus.rdata, bus.rlast);
          end
        end
      end
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
    end
    checks++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      errors++;
      $display("FAIL incr_done: rvalid=%b arready=%b, required 0 1", bus.rvalid, bus.arready);
    end
  endtask

  task automatic test_simultaneous();
    bit ok, okr;
    logic [3:0] id;
    mem[20] = 32'h5050A0A0;
    bus.arid = 4'd1; bus.araddr = 32'h50; bus.arlen = 8'h00; bus.arsize = 3'd2;
    bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
    bus.awid = 4'd2; bus.awaddr = 32'h60; bus.awlen = 8'h00; bus.awsize = 3'd2;
    bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
    #1;
    checks++;
    if (bus.arready !== 1'b0 || bus.awready !== 1'b1) begin
      errors++;
      $display("FAIL simul_ready: arready=%b awready=%b, required 0 1", bus.arready, bus.awready);
    end
    tick();
    bus.awvalid = 1'b0;
    checks++;
    if (bus.wready !== 1'b1 || bus.arready !== 1'b0) begin
      errors++;
      $display("FAIL simul_write_first: wready=%b arready=%b, required 1 0", bus.wready, bus.arready);
    end
    send_w(32'hCAFEF00D, 4'hF, 1'b1, ok);
    finish_b(okr, id);
    checks++;
    if (!ok || !okr || id !== 4'd2 || mem[24] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL simul_write: ok=%b bid=%0d mem24=%h, required 1 2 cafef00d", ok && okr, id, mem[24]);
    end
    send_ar(32'h50, 8'h00, BURST_INCR, 4'd1, ok);
    wait_rvalid(okr);
    checks++;
    if (!ok || !okr || bus.rdata !== 32'h5050A0A0 || bus.rid !== 4'd1) begin
      errors++;
      $display("FAIL simul_read: ok=%b rdata=%h rid=%0d, required 1 5050a0a0 1", ok && okr, bus.rdata, bus.rid);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic test_fixed_write();
    bit ok, okw;
    logic [3:0] id;
    mem[12] = 32'h0;
    mem[13] = 32'h13131313;
    send_aw(32'h30, 8'h02, BURST_FIXED, 4'd4, ok);
    okw = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bit okb;
      send_w(32'(i), 4'hF, i == 3, okb);
      okw &= okb;
    end
    checks++;
    if (!ok || !okw || bus.bvalid !== 1'b1 || bus.bid !== 4'd4) begin
      errors++;
      $display("FAIL fixed_b: ok=%b bvalid=%b bid=%0d, required 1 1 4", ok && okw, bus.bvalid, bus.bid);
    end
    finish_b(ok, id);
    tick();
    checks++;
    if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
      errors++;
      $display("FAIL fixed_single_b: bvalid=%b awready=%b, required 0 1", bus.bvalid, bus.awready);
    end
    checks++;
    if (mem[12] !== 32'd3 || mem[13] !== 32'h13131313) begin
      errors++;
      $display("FAIL fixed_mem: word12=%h word13=%h, required 00000003 13131313", mem[12], mem[13]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, okr;
    logic [31:0] data;
    mem[30] = 32'h77;
    send_ar(32'h78, 8'h00, BURST_INCR, 4'd5, ok);
    wait_rvalid(okr);
    checks++;
    if (!ok || !okr || bus.rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: ok=%b rvalid=%b, required 1 1", ok && okr, bus.rvalid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_post: rvalid=%b arready=%b, required 0 1", bus.rvalid, bus.arready);
    end
    read_word(32'h78, 4'd5, data, ok);
    checks++;
    if (!ok || data !== 32'h77) begin
      errors++;
      $display("FAIL rst_mid_fresh: ok=%b rdata=%h, required 1 00000077", ok, data);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_byte_write();
    test_incr_burst();
    test_simultaneous();
    test_fixed_write();
    test_reset_mid();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_ram_slave.md
# axi_ram_slave

AXI3-subset responder that sits at the memory end of the CPU's AXI port. It accepts read and write transactions from the core's SRAM-like-to-AXI bridge, or from any single-outstanding AXI master, and serves them from an external synchronous single-port SRAM. It is the slave counterpart of that bridge. It supports single-beat and short INCR/FIXED bursts, echoes IDs, and always returns OKAY responses.

## Interface

Parameters:
- `ADDR_WIDTH`, default 14: SRAM word-address width. The byte address uses bits [ADDR_WIDTH+1:2]; upper bits are ignored, so access wraps modulo the RAM size.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `arid`  in  4  read ID.
- `araddr`  in  32  read byte address.
- `arlen`  in  8  read beats minus 1; only [3:0] is used.
- `arsize`  in  3  read beat size.
- `arburst`  in  2  read burst type: 0 FIXED, 1 INCR.
- `arvalid`  in  1  read address valid.
- `arready`  out  1  read address ready.
- `rid`  out  4  read ID echo.
- `rdata`  out  32  read data.
- `rresp`  out  2  read response.
- `rlast`  out  1  last read beat.
- `rvalid`  out  1  read data valid.
- `rready`  in  1  read data ready.
- `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awvalid`: inputs, same widths and meaning as the AR channel, for writes.
- `awready`  out  1  write address ready.
- `wdata`  in  32  write data.
- `wstrb`  in  4  byte lane enables.
- `wlast`  in  1  last write beat; ignored.
- `wvalid`  in  1  write data valid.
- `wready`  out  1  write data ready.
- `bid`  out  4  write ID echo.
- `bresp`  out  2  write response.
- `bvalid`  out  1  write response valid.
- `bready`  in  1  write response ready.
- `sram_en`  out  1  SRAM read enable.
- `sram_wen`  out  4  SRAM byte write enables.
- `sram_addr`  out  ADDR_WIDTH  SRAM word address.
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  32  SRAM read data, valid the cycle after `sram_en`.

## Operation

- FSM states: IDLE, RD_ADDR, RD_LOAD, RD_DATA, WR_DATA, WR_RESP. One transaction outstanding at a time.
- IDLE:
  - `awready` = 1.
  - `arready` = !`awvalid`, so a write wins a simultaneous request.
  - On an AW or AR handshake, capture id, addr, len[3:0], size and burst. Clear the beat counter. Go to WR_DATA or RD_ADDR.
- RD_ADDR: `sram_en` = 1, `sram_addr` = addr_r[ADDR_WIDTH+1:2]. Go to RD_LOAD.
- RD_LOAD: latch `sram_rdata` into rdata_r. Go to RD_DATA.
- RD_DATA:
  - `rvalid` = 1, `rdata` = rdata_r, `rid` = id_r, `rresp` = 0.
  - `rlast` = 1 when beat counter == len_r.
  - On `rvalid`&&`rready`: if last, go to IDLE. Otherwise increment the counter, advance the address, and go to RD_ADDR.
- WR_DATA:
  - `wready` = 1.
  - On `wvalid`&&`wready`, in the same cycle: `sram_wen` = `wstrb`, `sram_wdata` = `wdata`, `sram_addr` = addr_r word.
  - If counter == len_r, go to WR_RESP. Otherwise increment the counter and advance the address.
- WR_RESP: `bvalid` = 1, `bid` = id_r, `bresp` = 0. On `bready`, go to IDLE.
- Address advance:
  - FIXED: unchanged.
  - INCR: addr_r + (1 << size), 32-bit add that wraps.
  - Any other burst code is treated as INCR.
- Narrow sizes (0, 1):
  - Read returns the full aligned word; the master selects the lanes.
  - Write lanes come from `wstrb` only; size does not gate lanes.
- `sram_en` and `sram_wen` are never asserted in the same cycle.

## Timing

- Reset values: state IDLE; `arready`/`awready` = 1 after reset deasserts; all other outputs 0 (`rvalid`, `wready`, `bvalid`, `rlast`, `sram_en`, `sram_wen`, `rdata`, `rid`, `bid`).
- Reset mid-transaction: return to IDLE on the next edge and drop the transaction, with no response.
- Read latency: AR handshake in cycle T → `sram_en` at T+1 → `rvalid` at T+3. Each further beat costs 3 cycles after the previous R handshake.
- Write: AW handshake in cycle T → `wready` at T+1. SRAM write in each W handshake cycle. `bvalid` the cycle after the final W handshake.
- Backpressure:
  - `rvalid`, `rdata` and `rlast` hold stable until `rready`.
  - `bvalid` and `bid` hold until `bready`.
- Burst length: len[3:0] = 15 gives 16 beats; arlen/awlen[7:4] are ignored.

## Structure

- Package `axi_ram_pkg` holds:
  - burst codes: FIXED = 0, INCR = 1;
  - response codes: OKAY = 0, SLVERR = 2 (reserved);
  - the FSM state enum.
- Sub-module `axi_ram_addr_gen`: combinational next-address from addr, size and burst. Shared by the read and write paths.

## Test plan

- Single read: preload word 5 = 0xDEADBEEF; araddr = 0x14, arlen = 0, arid = 3 → `rvalid` at T+3 with rdata 0xDEADBEEF, rid 3, rlast 1, rresp 0.
- Byte write then read: awaddr = 0x22, wstrb = 0100, wdata = 0x00AB0000 over word 8 = 0x11223344 → bvalid one cycle after W, bid echoed; read of 0x20 returns 0x11AB3344.
- INCR 4-beat read from 0x40, words 0x10..0x13, with rready low for 2 cycles on beat 2 → beats 0x10, 0x11, 0x12, 0x13 in order; data held during the stall; rlast only on the 4th beat.
- Simultaneous `arvalid` and `awvalid` in IDLE → write accepted first, `arready` = 0 that cycle; read completes after `bready`.
- FIXED 3-beat write to 0x30 with data 1, 2, 3 → word 12 = 3, word 13 untouched; one B response.
- Reset asserted in RD_DATA while rready = 0 → next cycle rvalid = 0 and arready = 1; a fresh read then completes normally.
